reset_sequencer: RTL and testbench

Synthesizable, parametrised reset generator for the SoC. It replaces the single fixed reset pulse driven around the `riscvsoc` core with a sequenced scheme. The block holds all downstream domains in reset for a programmable time, then releases `CHANNELS` reset outputs one at a time in staggered order. It also re-runs the full sequence on a software request or, optionally, on a watchdog timeout, and records which event caused the latest reset.

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/reset_seq_wdt.sv | 40 ++++
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and cause codes for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

endpackage

// File: rtl/reset_seq_wdt.sv
// rtl/reset_seq_wdt.sv - watchdog counter, only instantiated under RESET_SEQ_WDT_EN
// Counts enabled cycles since the last kick; expire is a single-cycle pulse at the terminal count.
module reset_seq_wdt #(
    parameter int WDT_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [W-1:0] WDT_LAST = W'(WDT_CYCLES - 1);

    logic [W-1:0] wcnt_q, wcnt_d;

    // A kick on the terminal cycle suppresses expiry.
    always_comb begin
        wcnt_d = wcnt_q;
        expire = 1'b0;
        if (!enable || kick) begin
            wcnt_d = '0;
        end else if (wcnt_q == WDT_LAST) begin
            expire = 1'b1;
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-channel reset generator
// Optional watchdog re-trigger is compiled in with RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDT_CYCLES     = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sw_req,
    input  logic                wdt_kick,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [1:0]          cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(CHANNELS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic [1:0]          cause_q, cause_d;
    logic                wdt_expire;

`ifdef RESET_SEQ_WDT_EN
    reset_seq_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == RUN),
        .kick   (wdt_kick),
        .expire (wdt_expire)
    );
`else
    logic unused_kick;
    assign unused_kick = wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_expire  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        cause_d   = cause_q;

        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = STAGGER;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STAGGER: begin
                if (sw_req) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cause_d   = CAUSE_SW;
                end else if (cnt_q == STAGGER_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_out_d[k] = 1'b0;
                        end
                    end
                    // Last channel released: ready rises on the same edge.
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (sw_req || wdt_expire) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cause_d   = sw_req ? CAUSE_SW : CAUSE_WDT;
                end
            end

            default: begin
                state_d   = HOLD;
                cnt_d     = '0;
                idx_d     = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_EXT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Watchdog scenarios run only when RESET_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1, sw_a = 1'b0, kick_a = 1'b0;
    logic [3:0] rst_a;
    logic       ready_a;
    logic [1:0] cause_a;

    logic       reset_b = 1'b1, sw_b = 1'b0, kick_b = 1'b0;
    logic [0:0] rst_b;
    logic       ready_b;
    logic [1:0] cause_b;

    int n_cmp = 0;
    int n_bad = 0;

    reset_sequencer u_a (
        .clk(clk), .reset(reset_a), .sw_req(sw_a), .wdt_kick(kick_a),
        .rst_out(rst_a), .ready(ready_a), .cause(cause_a)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) u_b (
        .clk(clk), .reset(reset_b), .sw_req(sw_b), .wdt_kick(kick_b),
        .rst_out(rst_b), .ready(ready_b), .cause(cause_b)
    );

`ifdef RESET_SEQ_WDT_EN
    logic       reset_c = 1'b1, sw_c = 1'b0, kick_c = 1'b0;
    logic [1:0] rst_c;
    logic       ready_c;
    logic [1:0] cause_c;

    reset_sequencer #(.CHANNELS(2), .HOLD_CYCLES(2), .STAGGER_CYCLES(2), .WDT_CYCLES(100)) u_c (
        .clk(clk), .reset(reset_c), .sw_req(sw_c), .wdt_kick(kick_c),
        .rst_out(rst_c), .ready(ready_c), .cause(cause_c)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        repeat (3) step();
        n_cmp++; if (rst_a !== 4'hF) begin n_bad++; $display("FAIL reset_rst: got %h want f", rst_a); end
        n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_a); end
        n_cmp++; if (cause_a !== 2'b01) begin n_bad++; $display("FAIL reset_cause: got %b want 01", cause_a); end
        sw_a = 1'b1;
        step();
        sw_a = 1'b0;
        n_cmp++; if (rst_a !== 4'hF || cause_a !== 2'b01) begin
            n_bad++; $display("FAIL reset_overrides_sw: rst %h cause %b want f 01", rst_a, cause_a);
        end
    endtask

    task automatic test_powerup();
        logic [3:0] exp_rst;
        reset_a = 1'b1;
        repeat (3) step();
        reset_a = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            for (int j = 0; j < 4; j++) exp_rst[j] = (e < 16 + 4 * (j + 1));
            n_cmp++; if (rst_a !== exp_rst || ready_a !== (e >= 32)) begin
                n_bad++; $display("FAIL powerup_e%0d: rst %h ready %b want %h %b", e, rst_a, ready_a, exp_rst, e >= 32);
            end
        end
        n_cmp++; if (cause_a !== 2'b01) begin n_bad++; $display("FAIL powerup_cause: got %b want 01", cause_a); end
    endtask

    task automatic test_sw_run();
        logic [3:0] exp_rst;
        sw_a = 1'b1;
        step();
        sw_a = 1'b0;
        n_cmp++; if (rst_a !== 4'hF || ready_a !== 1'b0 || cause_a !== 2'b10) begin
            n_bad++; $display("FAIL sw_run_entry: rst %h ready %b cause %b want f 0 10", rst_a, ready_a, cause_a);
        end
        for (int k = 1; k <= 32; k++) begin
            step();
            for (int j = 0; j < 4; j++) exp_rst[j] = (k < 16 + 4 * (j + 1));
            n_cmp++; if (rst_a !== exp_rst || ready_a !== (k >= 32)) begin
                n_bad++; $display("FAIL sw_run_k%0d: rst %h ready %b want %h %b", k, rst_a, ready_a, exp_rst, k >= 32);
            end
        end
        n_cmp++; if (cause_a !== 2'b10) begin n_bad++; $display("FAIL sw_run_cause: got %b want 10", cause_a); end
    endtask

    task automatic test_sw_hold();
        logic [3:0] exp_rst;
        reset_a = 1'b1;
        repeat (3) step();
        reset_a = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            for (int j = 0; j < 4; j++) exp_rst[j] = (e < 16 + 4 * (j + 1));
            n_cmp++; if (rst_a !== exp_rst || ready_a !== (e >= 32)) begin
                n_bad++; $display("FAIL sw_hold_e%0d: rst %h ready %b want %h %b", e, rst_a, ready_a, exp_rst, e >= 32);
            end
            sw_a = (e == 5);
        end
        sw_a = 1'b0;
        n_cmp++; if (cause_a !== 2'b01) begin n_bad++; $display("FAIL sw_hold_cause: got %b want 01", cause_a); end
    endtask

    task automatic test_sw_stagger();
        reset_a = 1'b1;
        repeat (3) step();
        reset_a = 1'b0;
        repeat (21) step();
        n_cmp++; if (rst_a !== 4'hE) begin n_bad++; $display("FAIL sw_stag_pre: got %h want e", rst_a); end
        sw_a = 1'b1;
        step();
        sw_a = 1'b0;
        n_cmp++; if (rst_a !== 4'hF || ready_a !== 1'b0 || cause_a !== 2'b10) begin
            n_bad++; $display("FAIL sw_stag_entry: rst %h ready %b cause %b want f 0 10", rst_a, ready_a, cause_a);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++; if (rst_a !== ((k < 20) ? 4'hF : 4'hE)) begin
                n_bad++; $display("FAIL sw_stag_k%0d: got %h want %h", k, rst_a, (k < 20) ? 4'hF : 4'hE);
            end
        end
    endtask

    task automatic test_reset_stagger();
        logic [3:0] exp_rst;
        repeat (4) step();
        n_cmp++; if (rst_a !== 4'hC) begin n_bad++; $display("FAIL rst_stag_pre: got %h want c", rst_a); end
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        n_cmp++; if (rst_a !== 4'hF || ready_a !== 1'b0 || cause_a !== 2'b01) begin
            n_bad++; $display("FAIL rst_stag_entry: rst %h ready %b cause %b want f 0 01", rst_a, ready_a, cause_a);
        end
        for (int e = 1; e <= 32; e++) begin
            step();
            for (int j = 0; j < 4; j++) exp_rst[j] = (e < 16 + 4 * (j + 1));
            n_cmp++; if (rst_a !== exp_rst || ready_a !== (e >= 32)) begin
                n_bad++; $display("FAIL rst_stag_e%0d: rst %h ready %b want %h %b", e, rst_a, ready_a, exp_rst, e >= 32);
            end
        end
    endtask

    task automatic test_small();
        n_cmp++; if (rst_b !== 1'b1 || ready_b !== 1'b0 || cause_b !== 2'b01) begin
            n_bad++; $display("FAIL small_reset: rst %b ready %b cause %b want 1 0 01", rst_b, ready_b, cause_b);
        end
        reset_b = 1'b0;
        step();
        n_cmp++; if (rst_b !== 1'b1 || ready_b !== 1'b0) begin
            n_bad++; $display("FAIL small_e1: rst %b ready %b want 1 0", rst_b, ready_b);
        end
        step();
        n_cmp++; if (rst_b !== 1'b0 || ready_b !== 1'b1) begin
            n_bad++; $display("FAIL small_e2: rst %b ready %b want 0 1", rst_b, ready_b);
        end
        sw_b = 1'b1;
        step();
        sw_b = 1'b0;
        n_cmp++; if (rst_b !== 1'b1 || ready_b !== 1'b0 || cause_b !== 2'b10) begin
            n_bad++; $display("FAIL small_sw: rst %b ready %b cause %b want 1 0 10", rst_b, ready_b, cause_b);
        end
        step();
        n_cmp++; if (rst_b !== 1'b1) begin n_bad++; $display("FAIL small_sw_hold: got %b want 1", rst_b); end
        step();
        n_cmp++; if (rst_b !== 1'b0 || ready_b !== 1'b1) begin
            n_bad++; $display("FAIL small_sw_release: rst %b ready %b want 0 1", rst_b, ready_b);
        end
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_wdt();
        reset_c = 1'b0;
        repeat (6) step();
        n_cmp++; if (ready_c !== 1'b1 || rst_c !== 2'b00) begin
            n_bad++; $display("FAIL wdt_run: ready %b rst %b want 1 00", ready_c, rst_c);
        end
        for (int k = 1; k <= 100; k++) begin
            step();
            n_cmp++; if (ready_c !== (k < 100)) begin
                n_bad++; $display("FAIL wdt_expire_k%0d: ready %b want %b", k, ready_c, k < 100);
            end
        end
        n_cmp++; if (cause_c !== 2'b11 || rst_c !== 2'b11) begin
            n_bad++; $display("FAIL wdt_cause: cause %b rst %b want 11 11", cause_c, rst_c);
        end
        repeat (6) step();
        repeat (99) step();
        kick_c = 1'b1;
        step();
        kick_c = 1'b0;
        n_cmp++; if (ready_c !== 1'b1 || cause_c !== 2'b11) begin
            n_bad++; $display("FAIL wdt_coincident_kick: ready %b cause %b want 1 11", ready_c, cause_c);
        end
        for (int k = 1; k <= 300; k++) begin
            step();
            kick_c = (k % 50 == 0);
            n_cmp++; if (ready_c !== 1'b1) begin
                n_bad++; $display("FAIL wdt_kicked_k%0d: ready %b want 1", k, ready_c);
            end
        end
        kick_c = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_sw_run();
        test_sw_hold();
        test_sw_stagger();
        test_reset_stagger();
        test_small();
`ifdef RESET_SEQ_WDT_EN
        test_wdt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
